// File: rtl/bias_relu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bias_relu_sequencer
// Description : Per-channel bias add with saturation and optional ReLU over a
//               channel-major accumulator stream; tracks channel/pixel position.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_relu_sequencer #(
    parameter int NUM_CH  = 128,
    parameter int NUM_PIX = 729,
    parameter int DW      = 16,
    parameter int RELU_EN = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [NUM_CH-1:0][DW-1:0]         bias_mem,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DW-1:0]                     in_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DW-1:0]                     out_data,
    output logic [$clog2(NUM_CH)-1:0]         out_ch,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done
);

    localparam int CW = $clog2(NUM_CH);
    localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam logic [CW-1:0] c_ch_last  = CW'(NUM_CH - 1);
    localparam logic [PW-1:0] c_pix_last = PW'(NUM_PIX - 1);
    localparam logic [DW-1:0] c_pos_max  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] c_neg_min  = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_ch_cnt;
    logic [PW-1:0]   r_pix_cnt;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_data;
    logic [CW-1:0]   r_out_ch;
    logic            r_out_last;

    logic            w_in_ready;
    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_last_word;
    logic            w_busy;
    logic            w_done;
    logic [DW-1:0]   w_bias;
    logic [DW:0]     w_bias_mag;
    logic [DW:0]     w_bias_tc;
    logic [DW:0]     w_sum;
    logic [DW-1:0]   w_sat;
    logic [DW-1:0]   w_result;

    // A new word is taken only when the single output slot is free or draining.
    assign w_in_ready  = (r_state == S_RUN) & (~r_out_valid | out_ready);
    assign w_in_xfer   = in_valid & w_in_ready;
    assign w_out_xfer  = r_out_valid & out_ready;
    assign w_last_word = (r_ch_cnt == c_ch_last) & (r_pix_cnt == c_pix_last);

    // Sign-magnitude bias to two's complement; a negative zero collapses to 0.
    assign w_bias     = bias_mem[r_ch_cnt];
    assign w_bias_mag = {2'b00, w_bias[DW-2:0]};
    assign w_bias_tc  = w_bias[DW-1] ? (~w_bias_mag + 1'b1) : w_bias_mag;
    assign w_sum      = {in_data[DW-1], in_data} + w_bias_tc;

    always_comb begin
        w_sat = w_sum[DW-1:0];
        case ({w_sum[DW], w_sum[DW-1]})
            2'b01:   w_sat = c_pos_max;
            2'b10:   w_sat = c_neg_min;
            default: w_sat = w_sum[DW-1:0];
        endcase
    end

    generate
        if (RELU_EN != 0) begin : g_relu_on
            assign w_result = w_sat[DW-1] ? '0 : w_sat;
        end else begin : g_relu_off
            assign w_result = w_sat;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_in_xfer && w_last_word) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                if (w_out_xfer) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
        end else if (w_in_xfer) begin
            if (r_ch_cnt == c_ch_last) begin
                r_ch_cnt  <= '0;
                r_pix_cnt <= (r_pix_cnt == c_pix_last) ? '0 : r_pix_cnt + 1'b1;
            end else begin
                r_ch_cnt  <= r_ch_cnt + 1'b1;
            end
        end
    end

    // Output slot: loads on every accepted word, otherwise holds until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_out_last  <= 1'b0;
        end else if (w_in_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_result;
            r_out_ch    <= r_ch_cnt;
            r_out_last  <= w_last_word;
        end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_last  = r_out_last;
    assign busy      = w_busy;
    assign done      = w_done;

endmodule
`default_nettype wire

// File: tb/tb_bias_relu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bias_relu_sequencer
// Description : Directed + random bench for bias_relu_sequencer, ReLU on and off.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bias_relu_sequencer;

    localparam int TB_CH  = 128;
    localparam int TB_PIX = 4;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        start;
    logic [TB_CH-1:0][15:0]      bias_tbl;
    logic                        in_valid;
    logic [15:0]                 in_data;
    logic                        out_ready;

    logic        in_ready_r, out_valid_r, out_last_r, busy_r, done_r;
    logic [15:0] out_data_r;
    logic [6:0]  out_ch_r;
    logic        in_ready_p, out_valid_p, out_last_p, busy_p, done_p;
    logic [15:0] out_data_p;
    logic [6:0]  out_ch_p;

    bias_relu_sequencer #(.NUM_CH(TB_CH), .NUM_PIX(TB_PIX), .DW(16), .RELU_EN(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .start(start), .bias_mem(bias_tbl),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .out_ch(out_ch_r), .out_last(out_last_r), .busy(busy_r), .done(done_r)
    );

    bias_relu_sequencer #(.NUM_CH(TB_CH), .NUM_PIX(TB_PIX), .DW(16), .RELU_EN(0)) u_pass (
        .clk(clk), .rst_n(rst_n), .start(start), .bias_mem(bias_tbl),
        .in_valid(in_valid), .in_ready(in_ready_p), .in_data(in_data),
        .out_valid(out_valid_p), .out_ready(out_ready), .out_data(out_data_p),
        .out_ch(out_ch_p), .out_last(out_last_p), .busy(busy_p), .done(done_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dr;
        logic [15:0] dp;
        logic [6:0]  ch;
        logic        last;
    } exp_t;

    exp_t q[$];
    bit   running;
    int   m_ch, m_pix;
    int   n_checks, n_fail, n_done_seen;

    function automatic logic [15:0] ref_calc(input logic [15:0] x, input logic [15:0] b, input bit relu);
        int bv, s;
        bv = int'(b[14:0]);
        if (b[15]) bv = -bv;
        s = int'($signed(x)) + bv;
        if (s > 32767)  s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return 16'(s);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", 32'(out_valid_r), 32'(0));
        check("rst_out_data_r", 32'(out_data_r), 32'(0));
        check("rst_out_data_p", 32'(out_data_p), 32'(0));
        check("rst_out_ch", 32'(out_ch_r), 32'(0));
        check("rst_out_last", 32'(out_last_r), 32'(0));
        check("rst_busy", 32'(busy_r), 32'(0));
        check("rst_done", 32'(done_r), 32'(0));
        check("rst_in_ready", 32'(in_ready_r), 32'(0));
    endtask

    // One clock: drive, check at the falling edge against the model, then advance the model.
    task automatic cycle(input bit st, input bit iv, input logic [15:0] id, input bit ordy);
        exp_t e;
        bit idle_before, exp_ir, out_x, in_x, exp_done;
        start = st; in_valid = iv; in_data = id; out_ready = ordy;
        @(negedge clk);
        idle_before = !running && (q.size() == 0);
        exp_ir      = running && (q.size() == 0 || ordy);
        out_x       = (q.size() != 0) && ordy;
        exp_done    = out_x && q[0].last;
        check("in_ready", 32'(in_ready_r), 32'(exp_ir));
        check("in_ready_p", 32'(in_ready_p), 32'(exp_ir));
        check("out_valid", 32'(out_valid_r), 32'(q.size() != 0));
        check("busy", 32'(busy_r), 32'(!idle_before));
        check("done", 32'(done_r), 32'(exp_done));
        if (q.size() != 0) begin
            check("out_data_relu", 32'(out_data_r), 32'(q[0].dr));
            check("out_data_pass", 32'(out_data_p), 32'(q[0].dp));
            check("out_ch", 32'(out_ch_r), 32'(q[0].ch));
            check("out_last", 32'(out_last_r), 32'(q[0].last));
        end
        if (done_r) n_done_seen++;
        in_x = exp_ir && iv;
        if (out_x) void'(q.pop_front());
        if (in_x) begin
            e.dr   = ref_calc(id, bias_tbl[m_ch], 1'b1);
            e.dp   = ref_calc(id, bias_tbl[m_ch], 1'b0);
            e.ch   = 7'(m_ch);
            e.last = (m_ch == TB_CH - 1) && (m_pix == TB_PIX - 1);
            q.push_back(e);
            if (e.last) running = 0;
            m_ch++;
            if (m_ch == TB_CH) begin
                m_ch = 0;
                m_pix++;
            end
        end
        if (st && idle_before) begin
            running = 1; m_ch = 0; m_pix = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int budget;
        n_checks = 0; n_fail = 0; n_done_seen = 0;
        running = 0; m_ch = 0; m_pix = 0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < TB_CH; i++) bias_tbl[i] = 16'($urandom);
        bias_tbl[0] = 16'h0115;
        bias_tbl[1] = 16'h8019;
        bias_tbl[2] = 16'h0115;
        bias_tbl[3] = 16'h8019;
        bias_tbl[4] = 16'h8000;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 16'h0, 1'b1);
        cycle(1'b1, 1'b0, 16'h0, 1'b1);

        // Directed arithmetic: +bias, ReLU clamp, positive/negative saturation.
        cycle(1'b0, 1'b1, 16'd100, 1'b1);
        check("t1_data", 32'(out_data_r), 32'd377);
        check("t1_ch", 32'(out_ch_r), 32'd0);
        cycle(1'b0, 1'b1, 16'd10, 1'b1);
        check("t2_relu", 32'(out_data_r), 32'h0);
        check("t2_pass", 32'(out_data_p), 32'hFFF1);
        cycle(1'b0, 1'b1, 16'h7F00, 1'b1);
        check("t3_pos_sat", 32'(out_data_p), 32'h7FFF);
        cycle(1'b0, 1'b1, 16'h8005, 1'b1);
        check("t3_neg_sat", 32'(out_data_p), 32'h8000);
        check("t3_neg_relu", 32'(out_data_r), 32'h0);

        // Backpressure with input pending; negative-zero bias on ch4.
        cycle(1'b0, 1'b1, 16'h1234, 1'b1);
        repeat (5) cycle(1'b0, 1'b1, 16'h5555, 1'b0);
        check("t4_hold_data", 32'(out_data_p), 32'h1234);
        check("t4_hold_ch", 32'(out_ch_r), 32'd4);
        cycle(1'b1, 1'b1, 16'($urandom), 1'b1);

        // Rest of the run with random stalls on both sides.
        n_done_seen = 0;
        budget = 0;
        while ((running || q.size() != 0) && budget < 20000) begin
            cycle(1'b0, $urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0);
            budget++;
        end
        check("t5_no_timeout", 32'(budget < 20000), 32'(1));
        check("t5_done_pulses", 32'(n_done_seen), 32'(1));
        cycle(1'b0, 1'b0, 16'h0, 1'b1);

        // Restart, then reset asynchronously part way through pixel 3.
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        check("t6_busy_after_start", 32'(busy_r), 32'(1));
        budget = 0;
        while (!(m_pix == 3 && m_ch == 40) && budget < 2000) begin
            cycle(1'b0, 1'b1, 16'($urandom), $urandom_range(0, 4) != 0);
            budget++;
        end
        check("t6_no_timeout", 32'(budget < 2000), 32'(1));
        rst_n = 1'b0;
        #1;
        check_reset_state();
        q.delete();
        running = 0; m_ch = 0; m_pix = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 16'h0, 1'b1);
        cycle(1'b0, 1'b1, 16'd100, 1'b1);
        check("t6_restart_ch", 32'(out_ch_r), 32'd0);
        check("t6_restart_data", 32'(out_data_r), 32'd377);
        cycle(1'b0, 1'b1, 16'd10, 1'b1);
        check("t6_next_ch", 32'(out_ch_r), 32'd1);
        repeat (3) cycle(1'b0, 1'b0, 16'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
